// File: rtl/fpna_pkg.sv
// Shared width defaults, chain-geometry helpers and field offsets for the
// LIF neuron array.
package fpna_pkg;

  localparam int DEF_N_IN      = 10;
  localparam int DEF_N_OUT     = 10;
  localparam int DEF_W_BITS    = 4;
  localparam int DEF_THR_BITS  = 8;
  localparam int DEF_LEAK_BITS = 3;
  localparam int DEF_ACC_BITS  = 10;

  // Field offsets inside one neuron slice: leak at the bottom, then thr, then weights
  localparam int LEAK_LSB = 0;
  localparam int THR_LSB  = LEAK_LSB + DEF_LEAK_BITS;
  localparam int W_LSB    = THR_LSB + DEF_THR_BITS;

  function automatic int nw(input int n_in, input int w_bits,
                            input int thr_bits, input int leak_bits);
    return n_in * w_bits + thr_bits + leak_bits;
  endfunction

  function automatic int cfg_len(input int n_out, input int n_in, input int w_bits,
                                 input int thr_bits, input int leak_bits);
    return n_out * nw(n_in, w_bits, thr_bits, leak_bits);
  endfunction

endpackage

// File: rtl/fpna_neuron.sv
// One leaky integrate-and-fire neuron: weighted input sum, shift leak,
// saturating accumulate, threshold compare, membrane and spike flops.
module fpna_neuron
  import fpna_pkg::*;
#(
  parameter int N_IN      = DEF_N_IN,
  parameter int W_BITS    = DEF_W_BITS,
  parameter int THR_BITS  = DEF_THR_BITS,
  parameter int LEAK_BITS = DEF_LEAK_BITS,
  parameter int ACC_BITS  = DEF_ACC_BITS,
  localparam int NW       = nw(N_IN, W_BITS, THR_BITS, LEAK_BITS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NW-1:0]              cfg,
  input  logic [N_IN-1:0]            in_bus,
  input  logic                       frozen,
  input  logic                       clr,
  input  logic                       run,
  output logic                       spike
);

  localparam int THR_OFS = LEAK_LSB + LEAK_BITS;
  localparam int W_OFS   = THR_OFS + THR_BITS;
  // Wide enough that leak + full input sum can never wrap before saturation
  localparam int EXT     = ACC_BITS + W_BITS + $clog2(N_IN + 1) + 1;
  localparam logic signed [EXT-1:0] ACC_MAX = EXT'((2 ** (ACC_BITS - 1)) - 1);
  localparam logic signed [EXT-1:0] ACC_MIN = ~ACC_MAX;

  logic signed [ACC_BITS-1:0] acc_r;
  logic        [LEAK_BITS-1:0] leak_s;
  logic        [THR_BITS-1:0]  thr_s;
  logic signed [W_BITS-1:0]    w_s;
  logic signed [EXT-1:0]       sum_s, acc_ext_s, leaked_s, raw_s, nxt_s, thr_ext_s;
  logic                        fire_s;

  // Next-membrane datapath
  always_comb begin
    leak_s    = cfg[LEAK_LSB +: LEAK_BITS];
    thr_s     = cfg[THR_OFS +: THR_BITS];
    thr_ext_s = EXT'(thr_s);
    w_s       = '0;
    sum_s     = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_s = cfg[W_OFS + i * W_BITS +: W_BITS];
      if (in_bus[i]) begin
        sum_s = sum_s + EXT'(w_s);
      end else begin
        sum_s = sum_s;
      end
    end
    acc_ext_s = EXT'(acc_r);
    if (leak_s == '0) begin
      leaked_s = acc_ext_s;
    end else begin
      leaked_s = acc_ext_s - (acc_ext_s >>> leak_s);
    end
    raw_s = leaked_s + sum_s;
    if (raw_s > ACC_MAX) begin
      nxt_s = ACC_MAX;
    end else if (raw_s < ACC_MIN) begin
      nxt_s = ACC_MIN;
    end else begin
      nxt_s = raw_s;
    end
    fire_s = (nxt_s >= thr_ext_s);
  end

  // Membrane and spike registers; configuration freeze beats clear beats run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= '0;
      spike <= 1'b0;
    end else if (frozen || clr) begin
      acc_r <= '0;
      spike <= 1'b0;
    end else if (run) begin
      if (fire_s) begin
        acc_r <= '0;
        spike <= 1'b1;
      end else begin
        acc_r <= nxt_s[ACC_BITS-1:0];
        spike <= 1'b0;
      end
    end else begin
      acc_r <= acc_r;
      spike <= 1'b0;
    end
  end

endmodule

// File: rtl/fpna_lif_array.sv
// Field-programmable array of LIF neurons: serial config chain, load-length
// validation and N_OUT neuron instances.
module fpna_lif_array
  import fpna_pkg::*;
#(
  parameter int N_IN      = DEF_N_IN,
  parameter int N_OUT     = DEF_N_OUT,
  parameter int W_BITS    = DEF_W_BITS,
  parameter int THR_BITS  = DEF_THR_BITS,
  parameter int LEAK_BITS = DEF_LEAK_BITS,
  parameter int ACC_BITS  = DEF_ACC_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             config_en,
  input  logic             bs_in,
  output logic             bs_out,
  input  logic             nrn_clr,
  input  logic [N_IN-1:0]  in_bus,
  output logic [N_OUT-1:0] out_bus,
  output logic             cfg_valid
);

  localparam int NW       = nw(N_IN, W_BITS, THR_BITS, LEAK_BITS);
  localparam int CFG_LEN  = cfg_len(N_OUT, N_IN, W_BITS, THR_BITS, LEAK_BITS);
  localparam int CNT_BITS = $clog2(CFG_LEN + 2);

  logic [CFG_LEN-1:0]  chain_r;
  logic [CNT_BITS-1:0] count_r;
  logic                cfg_en_d_r;
  logic                cfg_valid_r;
  logic                run_s;

  // Serial configuration chain, MSB is the tail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_r <= '0;
    end else if (config_en) begin
      chain_r <= {chain_r[CFG_LEN-2:0], bs_in};
    end else begin
      chain_r <= chain_r;
    end
  end

  // Session bit counter and load validation; the rising-edge cycle counts as bit 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_en_d_r  <= 1'b0;
      count_r     <= '0;
      cfg_valid_r <= 1'b0;
    end else begin
      cfg_en_d_r <= config_en;
      if (config_en && !cfg_en_d_r) begin
        count_r     <= CNT_BITS'(1);
        cfg_valid_r <= 1'b0;
      end else if (config_en) begin
        if (count_r != CNT_BITS'(CFG_LEN + 1)) begin
          count_r <= count_r + CNT_BITS'(1);
        end else begin
          count_r <= count_r;
        end
      end else if (cfg_en_d_r) begin
        cfg_valid_r <= (count_r == CNT_BITS'(CFG_LEN));
      end else begin
        cfg_valid_r <= cfg_valid_r;
      end
    end
  end

  // Neurons only integrate with a validated configuration
  always_comb begin
    run_s = ena & cfg_valid_r;
  end

  assign bs_out    = chain_r[CFG_LEN-1];
  assign cfg_valid = cfg_valid_r;

  for (genvar j = 0; j < N_OUT; j++) begin : g_nrn
    fpna_neuron #(
      .N_IN      (N_IN),
      .W_BITS    (W_BITS),
      .THR_BITS  (THR_BITS),
      .LEAK_BITS (LEAK_BITS),
      .ACC_BITS  (ACC_BITS)
    ) u_nrn (
      .clk    (clk),
      .rst_n  (rst_n),
      .cfg    (chain_r[j*NW +: NW]),
      .in_bus (in_bus),
      .frozen (config_en),
      .clr    (nrn_clr),
      .run    (run_s),
      .spike  (out_bus[j])
    );
  end

endmodule

// File: tb/tb_fpna_lif_array.sv
// Self-checking bench for fpna_lif_array: directed load/readback/priority steps
// plus randomized runs against an arithmetic neuron model.
module tb_fpna_lif_array;

  localparam int N_IN = 10, N_OUT = 10, W_BITS = 4, THR_BITS = 8, LEAK_BITS = 3, ACC_BITS = 10;
  localparam int NW = N_IN * W_BITS + THR_BITS + LEAK_BITS;
  localparam int CFG_LEN = N_OUT * NW;

  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0, config_en = 1'b0, bs_in = 1'b0, nrn_clr = 1'b0;
  logic [N_IN-1:0]  in_bus = '0;
  logic             bs_out, cfg_valid;
  logic [N_OUT-1:0] out_bus;

  always #5 clk = ~clk;

  fpna_lif_array dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .config_en(config_en), .bs_in(bs_in),
    .bs_out(bs_out), .nrn_clr(nrn_clr), .in_bus(in_bus), .out_bus(out_bus),
    .cfg_valid(cfg_valid)
  );

  int n_assert = 0, n_fail = 0;
  int w_m[N_OUT][N_IN];
  int thr_m[N_OUT], leak_m[N_OUT], acc_m[N_OUT];
  logic [N_OUT-1:0] spk_m = '0;
  bit valid_m = 1'b0;
  logic [CFG_LEN-1:0] pat, cap, vec;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_cfg();
    for (int j = 0; j < N_OUT; j++) begin
      for (int i = 0; i < N_IN; i++) w_m[j][i] = 0;
      thr_m[j] = 255;
      leak_m[j] = 0;
    end
  endtask

  // Chain image of the model configuration
  task automatic pack(output logic [CFG_LEN-1:0] v);
    int t;
    v = '0;
    for (int j = 0; j < N_OUT; j++) begin
      t = leak_m[j];
      for (int k = 0; k < LEAK_BITS; k++) v[j*NW + k] = t[k];
      t = thr_m[j];
      for (int k = 0; k < THR_BITS; k++) v[j*NW + LEAK_BITS + k] = t[k];
      for (int i = 0; i < N_IN; i++) begin
        t = w_m[j][i];
        for (int k = 0; k < W_BITS; k++) v[j*NW + LEAK_BITS + THR_BITS + i*W_BITS + k] = t[k];
      end
    end
  endtask

  // Shift n bits (MSB of v first, zeros beyond CFG_LEN), then drop config_en for one edge
  task automatic shift_n(input int n, input logic [CFG_LEN-1:0] v);
    config_en = 1'b1;
    for (int k = 0; k < n; k++) begin
      bs_in = (k < CFG_LEN) ? v[CFG_LEN-1-k] : 1'b0;
      @(posedge clk); #1;
    end
    config_en = 1'b0;
    bs_in = 1'b0;
    @(posedge clk); #1;
    valid_m = (n == CFG_LEN);
    for (int j = 0; j < N_OUT; j++) acc_m[j] = 0;
    spk_m = '0;
  endtask

  task automatic load_model();
    pack(vec);
    shift_n(CFG_LEN, vec);
  endtask

  task automatic model_step(input logic [N_IN-1:0] inb, input bit clr, input bit en);
    int sum, leaked, nxt;
    for (int j = 0; j < N_OUT; j++) begin
      if (clr) begin
        acc_m[j] = 0; spk_m[j] = 1'b0;
      end else if (en && valid_m) begin
        sum = 0;
        for (int i = 0; i < N_IN; i++) if (inb[i]) sum += w_m[j][i];
        leaked = (leak_m[j] == 0) ? acc_m[j] : acc_m[j] - (acc_m[j] >>> leak_m[j]);
        nxt = leaked + sum;
        if (nxt > 511) nxt = 511;
        if (nxt < -512) nxt = -512;
        if (nxt >= thr_m[j]) begin
          spk_m[j] = 1'b1; acc_m[j] = 0;
        end else begin
          spk_m[j] = 1'b0; acc_m[j] = nxt;
        end
      end else begin
        spk_m[j] = 1'b0;
      end
    end
  endtask

  task automatic run_cycle(input string tag, input logic [N_IN-1:0] inb, input bit clr, input bit en);
    in_bus = inb; nrn_clr = clr; ena = en;
    @(posedge clk); #1;
    model_step(inb, clr, en);
    check({tag, "_out"}, 32'(out_bus), 32'(spk_m));
    check({tag, "_acc0"}, 32'(dut.g_nrn[0].u_nrn.acc_r), acc_m[0]);
  endtask

  initial begin
    #12;
    check("rst_out_bus", 32'(out_bus), 32'd0);
    check("rst_bs_out", 32'(bs_out), 32'd0);
    check("rst_cfg_valid", 32'(cfg_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int k = 0; k < CFG_LEN; k++) pat[k] = 1'($urandom_range(1, 0));
    shift_n(CFG_LEN - 1, pat);
    check("cnt_509", 32'(cfg_valid), 32'd0);
    shift_n(CFG_LEN, pat);
    check("cnt_510", 32'(cfg_valid), 32'd1);
    shift_n(CFG_LEN + 1, pat);
    check("cnt_511", 32'(cfg_valid), 32'd0);

    // Readback: a loaded pattern streams out of the tail unchanged
    shift_n(CFG_LEN, pat);
    check("rb_valid", 32'(cfg_valid), 32'd1);
    config_en = 1'b1; bs_in = 1'b0;
    for (int k = 0; k < CFG_LEN; k++) begin
      cap[CFG_LEN-1-k] = bs_out;
      @(posedge clk); #1;
      if (k == 0) check("cfg_out_zero", 32'(out_bus), 32'd0);
    end
    config_en = 1'b0;
    @(posedge clk); #1;
    n_assert++;
    assert (cap === pat) else begin
      n_fail++;
      $error("FAIL readback observed=%0h expected=%0h", cap[63:0], pat[63:0]);
    end

    clear_cfg();
    w_m[0][0] = 1; thr_m[0] = 1;
    load_model();
    for (int c = 0; c < 5; c++) run_cycle("pass", 10'b0000000001, 1'b0, 1'b1);
    check("pass_const", 32'(out_bus), 32'b0000000001);

    thr_m[0] = 3;
    load_model();
    for (int c = 0; c < 9; c++) run_cycle("integ", 10'b0000000001, 1'b0, 1'b1);

    w_m[0][0] = 4; thr_m[0] = 9; leak_m[0] = 1;
    load_model();
    for (int c = 0; c < 8; c++) run_cycle("leak", 10'b0000000001, 1'b0, 1'b1);

    clear_cfg();
    for (int i = 0; i < N_IN; i++) w_m[0][i] = -8;
    load_model();
    for (int c = 0; c < 9; c++) run_cycle("sat", '1, 1'b0, 1'b1);
    check("sat_floor", 32'(dut.g_nrn[0].u_nrn.acc_r), 32'hFFFF_FE00);

    // Clear beats a would-fire cycle; ena low holds the membrane
    clear_cfg();
    w_m[0][0] = 1; thr_m[0] = 1;
    load_model();
    run_cycle("pri_fire", 10'b0000000001, 1'b0, 1'b1);
    run_cycle("pri_clr", 10'b0000000001, 1'b1, 1'b1);
    check("pri_clr_out", 32'(out_bus), 32'd0);
    thr_m[0] = 3;
    load_model();
    run_cycle("hold_a", 10'b0000000001, 1'b0, 1'b1);
    run_cycle("hold_b", 10'b0000000001, 1'b0, 1'b0);
    check("hold_acc", 32'(dut.g_nrn[0].u_nrn.acc_r), 32'd1);

    for (int j = 0; j < N_OUT; j++) begin
      for (int i = 0; i < N_IN; i++) w_m[j][i] = int'($urandom_range(15, 0)) - 8;
      thr_m[j] = int'($urandom_range(40, 0));
      leak_m[j] = int'($urandom_range(7, 0));
    end
    load_model();
    for (int c = 0; c < 60; c++)
      run_cycle("rand", N_IN'($urandom), ($urandom_range(15, 0) == 0), ($urandom_range(7, 0) != 0));

    // Asynchronous reset in the middle of a shift session
    config_en = 1'b1;
    for (int k = 0; k < 100; k++) begin
      bs_in = 1'($urandom_range(1, 0));
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(cfg_valid), 32'd0);
    check("mid_rst_bs_out", 32'(bs_out), 32'd0);
    n_assert++;
    assert (dut.chain_r === '0) else begin
      n_fail++;
      $error("FAIL mid_rst_chain observed=%0h expected=0", dut.chain_r[63:0]);
    end
    config_en = 1'b0; bs_in = 1'b0;
    valid_m = 1'b0;
    for (int j = 0; j < N_OUT; j++) acc_m[j] = 0;
    spk_m = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) run_cycle("post_rst", '1, 1'b0, 1'b1);
    check("post_rst_valid", 32'(cfg_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
